player_mode_ctrl: RTL and testbench
===================================

Name: player_mode_ctrl

Overview:
Parametrised top-level mode controller for the music player. It sequences SELECT, PLAY, MENU (pause menu) and DONE states from push-button events and the player's song_over strobe. It drives the song index, play enable, restart strobe, exit strobe and blink indication consumed by the songbook and display blocks. Compared with the previous controller it adds an N-song index with wrap-around, selectable play modes with auto-advance, a cursor-driven pause menu and glitch-free key edge detection.

Parameters:
NUM_SONGS, 8, number of songs; index range 0..NUM_SONGS-1; must be >= 2.
IDX_W, 3, width of song_idx; must satisfy 2**IDX_W >= NUM_SONGS.
TWINKLE_DIV, 25000000, clk cycles per blink half-period in SELECT; must be >= 2.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
enable  in  1  block enable; low forces soft reset
key_next  in  1  level; next song / next menu item
key_prev  in  1  level; previous song / previous menu item
key_ok  in  1  level; confirm
key_pause  in  1  level; pause toggle
key_mode  in  1  level; cycles play mode (SELECT only)
song_over  in  1  single-cycle strobe from songbook at end of song
song_idx  out  IDX_W  current song index
play_en  out  1  high only in PLAY
restart  out  1  one-cycle strobe: songbook restarts song_idx from its start
exit_pulse  out  1  one-cycle strobe on menu EXIT
menu_cur  out  2  pause-menu cursor: 0 CONTINUE, 1 RESTART, 2 RESELECT, 3 EXIT
play_mode  out  2  0 SINGLE, 1 REPEAT_ONE, 2 SEQUENTIAL, 3 LOOP_ALL
state_oh  out  4  one-hot state: bit0 SELECT, bit1 PLAY, bit2 MENU, bit3 DONE
twinkle  out  1  blink indication

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state SELECT; song_idx, menu_cur, play_mode = 0.
  - play_en, restart, exit_pulse, twinkle = 0; blink counter = 0.
  - Two-stage key history registers reset to all ones, so a key held through reset yields no event until it is released and pressed again.
- enable=0: same as reset, except play_mode is retained and key history keeps sampling.
- Key events:
  - Each key is registered into a two-stage history (k_q, k_qq); event = k_q & ~k_qq.
  - A key first sampled high at edge n has its effect visible after edge n+1 (2-cycle latency). Holding a key produces exactly one event.
  - song_over is used directly (no history).
- SELECT:
  - ok event: go to PLAY, restart=1.
  - Otherwise next: song_idx+1, wrapping NUM_SONGS-1 -> 0. prev: song_idx-1, wrapping 0 -> NUM_SONGS-1. next and prev in the same cycle: no change.
  - mode event: play_mode+1 mod 4; may coincide with next/prev; ignored if ok is present.
- PLAY:
  - song_over has priority over pause.
  - SINGLE: go to DONE.
  - REPEAT_ONE: restart=1, stay in PLAY.
  - SEQUENTIAL: if song_idx==NUM_SONGS-1 go to DONE; else song_idx+1, restart=1.
  - LOOP_ALL: song_idx+1 with wrap, restart=1.
  - pause event without song_over: go to MENU, menu_cur=0.
- MENU:
  - play_en=0 (songbook holds position).
  - ok event acts on menu_cur:
    - CONTINUE: go to PLAY, no restart.
    - RESTART: go to PLAY, restart=1.
    - RESELECT: go to SELECT, song_idx kept.
    - EXIT: go to SELECT, song_idx=0, exit_pulse=1.
  - Else pause event: go to PLAY (same as CONTINUE).
  - Else next/prev: menu_cur ±1 mod 4; both together = no change.
  - menu_cur is cleared on any exit from MENU.
- DONE: ok event goes to SELECT; all other inputs ignored.
- Strobes: restart and exit_pulse are registered and high for exactly one cycle, in the same cycle that state_oh shows the new state.
- song_over outside PLAY is ignored.
- twinkle:
  - In SELECT it toggles every TWINKLE_DIV cycles; the counter and twinkle are cleared on every entry to SELECT.
  - In MENU twinkle=1; in PLAY and DONE twinkle=0.
- state_oh is always exactly one-hot; an illegal state register value recovers to SELECT on the next edge.

Test Plan:
1. NUM_SONGS=5, reset, 6 next presses -> song_idx 1,2,3,4,0,1; then 2 prev presses -> 0,4; key held 100 cycles -> a single increment.
2. SELECT idx=2, ok -> after 2 cycles state_oh=0010, play_en=1, restart high exactly 1 cycle.
3. play_mode=SEQUENTIAL, idx=3 of 5: song_over -> idx=4 with restart; second song_over -> DONE (state_oh=1000), play_en=0; ok -> SELECT.
4. PLAY, pause -> MENU with menu_cur=0, twinkle=1; prev -> 3; ok -> SELECT, song_idx=0, exit_pulse for 1 cycle.
5. In PLAY, song_over and a pause event in the same cycle with LOOP_ALL, idx=4 of 5 -> idx=0, restart=1, state remains PLAY.
6. key_ok held high across reset release -> no transition until release and re-press; enable=0 mid-PLAY with play_mode=2 -> SELECT, idx=0, play_mode still 2.

Source files
------------

// File: rtl/player_mode_ctrl.sv
// player_mode_ctrl: music player mode sequencer (select/play/menu/done)
// with edge-detected keys, play modes, pause menu and select-state blink.
module player_mode_ctrl #(
  parameter int NUM_SONGS   = 8,
  parameter int IDX_W       = 3,
  parameter int TWINKLE_DIV = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             key_next,
  input  logic             key_prev,
  input  logic             key_ok,
  input  logic             key_pause,
  input  logic             key_mode,
  input  logic             song_over,
  output logic [IDX_W-1:0] song_idx,
  output logic             play_en,
  output logic             restart,
  output logic             exit_pulse,
  output logic [1:0]       menu_cur,
  output logic [1:0]       play_mode,
  output logic [3:0]       state_oh,
  output logic             twinkle
);
  typedef enum logic [1:0] {S_SELECT, S_PLAY, S_MENU, S_DONE} state_t;
  localparam int CW = $clog2(TWINKLE_DIV);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SONGS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TWINKLE_DIV - 1);
  state_t           r_state, w_state;
  logic [4:0]       r_k_q, r_k_qq, w_ev;
  logic             w_next, w_prev, w_ok, w_pause, w_modek;
  logic [IDX_W-1:0] r_idx, w_idx, w_inc, w_dec;
  logic [1:0]       r_cur, w_cur, r_mode, w_mode;
  logic             r_restart, w_restart, r_exit, w_exit, r_tw;
  logic [CW-1:0]    r_cnt;
  assign w_ev = r_k_q & ~r_k_qq;
  assign {w_modek, w_pause, w_ok, w_prev, w_next} = w_ev;
  assign w_inc = (r_idx == LAST) ? '0 : r_idx + 1'b1;
  assign w_dec = (r_idx == '0) ? LAST : r_idx - 1'b1;
  always_comb begin
    w_state   = r_state;
    w_idx     = r_idx;
    w_cur     = r_cur;
    w_mode    = r_mode;
    w_restart = 1'b0;
    w_exit    = 1'b0;
    case (r_state)
      S_SELECT: begin
        if (w_ok) begin
          w_state   = S_PLAY;
          w_restart = 1'b1;
        end else begin
          if (w_next ^ w_prev) w_idx = w_next ? w_inc : w_dec;
          if (w_modek) w_mode = r_mode + 2'd1;
        end
      end
      S_PLAY: begin
        // song_over wins over pause; only SINGLE and SEQUENTIAL-at-last stop
        if (song_over) begin
          w_restart = (r_mode != 2'd0) && !(r_mode == 2'd2 && r_idx == LAST);
          w_state   = w_restart ? S_PLAY : S_DONE;
          w_idx     = (r_mode[1] && w_restart) ? w_inc : r_idx;
        end else if (w_pause) begin
          w_state = S_MENU;
          w_cur   = '0;
        end
      end
      S_MENU: begin
        if (w_ok) begin
          w_cur     = '0;
          w_state   = r_cur[1] ? S_SELECT : S_PLAY;
          w_restart = (r_cur == 2'd1);
          w_exit    = (r_cur == 2'd3);
          w_idx     = (r_cur == 2'd3) ? '0 : r_idx;
        end else if (w_pause) begin
          w_cur   = '0;
          w_state = S_PLAY;
        end else if (w_next ^ w_prev) begin
          w_cur = w_next ? r_cur + 2'd1 : r_cur - 2'd1;
        end
      end
      S_DONE: w_state = w_ok ? S_SELECT : S_DONE;
      default: w_state = S_SELECT;
    endcase
  end
  // history resets to ones so a key held through reset needs a re-press
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k_q  <= '1;
      r_k_qq <= '1;
    end else begin
      r_k_q  <= {key_mode, key_pause, key_ok, key_prev, key_next};
      r_k_qq <= r_k_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_mode <= '0;
    else if (enable) r_mode <= w_mode;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      r_state   <= S_SELECT;
      r_idx     <= '0;
      r_cur     <= '0;
      r_restart <= 1'b0;
      r_exit    <= 1'b0;
      r_cnt     <= '0;
      r_tw      <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_idx     <= w_idx;
      r_cur     <= w_cur;
      r_restart <= w_restart;
      r_exit    <= w_exit;
      r_cnt     <= (r_state != S_SELECT || r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
      r_tw      <= (r_state == S_SELECT) && (r_tw ^ (r_cnt == CNT_MAX));
    end
  end
  assign song_idx   = r_idx;
  assign play_en    = (r_state == S_PLAY);
  assign restart    = r_restart;
  assign exit_pulse = r_exit;
  assign menu_cur   = r_cur;
  assign play_mode  = r_mode;
  assign state_oh   = 4'b0001 << r_state;
  assign twinkle    = (r_state == S_MENU) || (r_state == S_SELECT && r_tw);
endmodule

// File: tb/tb_player_mode_ctrl.sv
// tb_player_mode_ctrl: table-driven scoreboard bench for player_mode_ctrl
// (5 songs, short blink period) plus hand sequences for multi-cycle cases.
module tb_player_mode_ctrl;
  localparam logic [4:0] K_0 = 5'd0, K_N = 5'd1, K_P = 5'd2, K_O = 5'd4, K_PA = 5'd8, K_M = 5'd16;
  localparam logic [3:0] SEL = 4'b0001, PLY = 4'b0010, MNU = 4'b0100, DN = 4'b1000;
  typedef struct {
    logic [4:0] k;
    logic       so;
    logic [3:0] st;
    logic [2:0] idx;
    logic [1:0] pm;
    logic [1:0] cur;
    logic       rs;
    logic       ex;
    logic       tw;
    logic       twc;
  } vec_t;
  logic       clk = 0, rst_n = 0, enable = 1;
  logic       key_next = 0, key_prev = 0, key_ok = 0, key_pause = 0, key_mode = 0, song_over = 0;
  logic [2:0] song_idx;
  logic       play_en, restart, exit_pulse, twinkle;
  logic [1:0] menu_cur, play_mode;
  logic [3:0] state_oh;
  int         n_chk = 0, n_err = 0;
  vec_t       vecs[$];
  vec_t       exp_q[$];
  player_mode_ctrl #(.NUM_SONGS(5), .IDX_W(3), .TWINKLE_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .key_next(key_next), .key_prev(key_prev), .key_ok(key_ok),
    .key_pause(key_pause), .key_mode(key_mode), .song_over(song_over),
    .song_idx(song_idx), .play_en(play_en), .restart(restart), .exit_pulse(exit_pulse),
    .menu_cur(menu_cur), .play_mode(play_mode), .state_oh(state_oh), .twinkle(twinkle)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
  function automatic vec_t mk(input logic [4:0] k, input logic so, input logic [3:0] st,
                              input logic [2:0] idx, input logic [1:0] pm, input logic [1:0] cur,
                              input logic rs, input logic ex, input logic tw, input logic twc);
    mk = '{k, so, st, idx, pm, cur, rs, ex, tw, twc};
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask
  // called at a negedge; returns at the negedge after the event takes effect
  task automatic press(input logic [4:0] k, input logic so);
    {key_mode, key_pause, key_ok, key_prev, key_next} = k;
    @(negedge clk);
    {key_mode, key_pause, key_ok, key_prev, key_next} = K_0;
    song_over = so;
    @(negedge clk);
    song_over = 0;
  endtask
  initial begin
    vec_t       e;
    logic [14:0] act, want;
    vecs.push_back(mk(K_P,     0, SEL, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_N,     0, SEL, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_N,     0, SEL, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_N,     0, SEL, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_N,     0, SEL, 4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_N,     0, SEL, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_N,     0, SEL, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_P,     0, SEL, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_P,     0, SEL, 4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_P,     0, SEL, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_P,     0, SEL, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_O,     0, PLY, 2, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(K_PA,    0, MNU, 2, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(K_N,     0, MNU, 2, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk(K_N,     0, MNU, 2, 0, 2, 0, 0, 1, 1));
    vecs.push_back(mk(K_P,     0, MNU, 2, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk(K_N|K_P, 0, MNU, 2, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk(K_O,     0, PLY, 2, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(K_0,     1, DN,  2, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(K_N,     0, DN,  2, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(K_O,     0, SEL, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_M,     0, SEL, 2, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_M|K_N, 0, SEL, 3, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_O,     0, PLY, 3, 2, 0, 1, 0, 0, 1));
    vecs.push_back(mk(K_0,     1, PLY, 4, 2, 0, 1, 0, 0, 1));
    vecs.push_back(mk(K_0,     1, DN,  4, 2, 0, 0, 0, 0, 1));
    vecs.push_back(mk(K_O,     0, SEL, 4, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_M,     0, SEL, 4, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_O|K_M, 0, PLY, 4, 3, 0, 1, 0, 0, 1));
    vecs.push_back(mk(K_PA,    1, PLY, 0, 3, 0, 1, 0, 0, 1));
    vecs.push_back(mk(K_PA,    0, MNU, 0, 3, 0, 0, 0, 1, 1));
    vecs.push_back(mk(K_P,     0, MNU, 0, 3, 3, 0, 0, 1, 1));
    vecs.push_back(mk(K_O,     0, SEL, 0, 3, 0, 0, 1, 0, 0));
    vecs.push_back(mk(K_0,     1, SEL, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_M,     0, SEL, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_M|K_N, 0, SEL, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_O,     0, PLY, 1, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(K_0,     1, PLY, 1, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(K_PA,    0, MNU, 1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(K_N,     0, MNU, 1, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(K_N,     0, MNU, 1, 1, 2, 0, 0, 1, 1));
    vecs.push_back(mk(K_O,     0, SEL, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_O,     0, PLY, 1, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(K_PA,    0, MNU, 1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(K_PA,    0, PLY, 1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(K_PA,    0, MNU, 1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(K_O,     0, PLY, 1, 1, 0, 0, 0, 0, 1));
    repeat (2) @(negedge clk);
    chk("reset_state", {state_oh, song_idx, play_mode, menu_cur, play_en, restart, exit_pulse, twinkle},
        {SEL, 3'd0, 2'd0, 2'd0, 4'b0000});
    rst_n = 1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("twinkle_c%0d", i), twinkle, (i >= 4 && i < 8));
    end
    key_next = 1;
    repeat (3) @(negedge clk);
    chk("hold_first", song_idx, 3'd1);
    repeat (97) @(negedge clk);
    key_next = 0;
    repeat (2) @(negedge clk);
    chk("hold_single", song_idx, 3'd1);
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i]);
      press(vecs[i].k, vecs[i].so);
      e = exp_q.pop_front();
      act  = {state_oh, song_idx, play_mode, menu_cur, restart, exit_pulse, play_en, e.twc ? twinkle : e.tw};
      want = {e.st, e.idx, e.pm, e.cur, e.rs, e.ex, e.st == PLY, e.tw};
      n_chk++;
      if (act !== want) begin
        n_err++;
        $display("FAIL vec%0d: got st/idx/pm/cur/rs/ex/pe/tw=%b expected %b", i, act, want);
      end
    end
    press(K_PA, 0);
    chk("menu_enter", state_oh, MNU);
    press(K_N, 0);
    press(K_O, 0);
    chk("menu_restart", {state_oh, restart}, {PLY, 1'b1});
    @(negedge clk);
    chk("restart_width", {state_oh, restart}, {PLY, 1'b0});
    press(K_PA, 0);
    press(K_N, 0);
    press(K_N, 0);
    press(K_O, 0);
    chk("reselect", {state_oh, song_idx}, {SEL, 3'd1});
    press(K_M, 0);
    press(K_N, 0);
    press(K_O, 0);
    chk("play_pm2", {state_oh, song_idx, play_mode, play_en}, {PLY, 3'd2, 2'd2, 1'b1});
    enable = 0;
    @(negedge clk);
    enable = 1;
    chk("enable_low", {state_oh, song_idx, play_mode, menu_cur, play_en},
        {SEL, 3'd0, 2'd2, 2'd0, 1'b0});
    key_ok = 1;
    rst_n  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("ok_held_reset", {state_oh, play_mode}, {SEL, 2'd0});
    key_ok = 0;
    @(negedge clk);
    press(K_O, 0);
    chk("ok_repress", {state_oh, restart}, {PLY, 1'b1});
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
